// File: rtl/stump_io_ctrl.sv
// Purpose : memory-mapped I/O block on the Stump CPU bus (LED, switches, timer, TX FIFO).
// Latency : reads are combinational; writes land on the clock edge; switches see 2 edges of latency.
// Backpr. : TX FIFO drains over tx_valid/tx_ready; a push into a full FIFO is dropped and flags ovf.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   address, wdata      CPU address and data_out
//   mem_wen, mem_ren    CPU write / read strobes
//   io_sel              address falls inside the 16-word window
//   io_rdata            read data, zero unless io_sel && mem_ren
//   sw_in               asynchronous switch inputs
//   led                 LED register
//   tx_data, tx_valid   FIFO head byte and non-empty flag
//   tx_ready            consumer takes the head this cycle
//
// Register map (address[3:0])
//   0 LED  RW | 1 SW R | 2 TIMER RW | 3 TCTRL {wrap(W1C),en} | 4 TXDATA W
//   5 TXSTAT {count[7:4], ovf(W1C)[2], empty[1], full[0]} | 6..15 read 0

module stump_io_ctrl #(
  parameter logic [15:0] IO_BASE    = 16'hFF00,
  parameter int          FIFO_DEPTH = 4,
  parameter int          PRESCALE   = 16,
  parameter int          LED_W      = 8,
  parameter int          SW_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       address,
  input  logic [15:0]       wdata,
  input  logic              mem_wen,
  input  logic              mem_ren,
  output logic              io_sel,
  output logic [15:0]       io_rdata,
  input  logic [SW_W-1:0]   sw_in,
  output logic [LED_W-1:0]  led,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  localparam logic [3:0] OFF_LED    = 4'd0;
  localparam logic [3:0] OFF_SW     = 4'd1;
  localparam logic [3:0] OFF_TIMER  = 4'd2;
  localparam logic [3:0] OFF_TCTRL  = 4'd3;
  localparam logic [3:0] OFF_TXDATA = 4'd4;
  localparam logic [3:0] OFF_TXSTAT = 4'd5;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [LED_W-1:0] led_q,     led_d;
  logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
  logic [15:0]      timer_q,   timer_d;
  logic [PRE_W-1:0] pre_q,     pre_d;
  logic             en_q,      en_d;
  logic             wrap_q,    wrap_d;
  logic             ovf_q,     ovf_d;
  logic [PTR_W-1:0] wp_q,      wp_d;
  logic [PTR_W-1:0] rp_q,      rp_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [7:0]       mem_q [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [3:0] off;
  logic       wr_en;
  logic       wr_led, wr_timer, wr_tctrl, wr_txdata, wr_txstat;

  assign io_sel    = (address[15:4] == IO_BASE[15:4]);
  assign off       = address[3:0];
  assign wr_en     = mem_wen && io_sel;
  assign wr_led    = wr_en && (off == OFF_LED);
  assign wr_timer  = wr_en && (off == OFF_TIMER);
  assign wr_tctrl  = wr_en && (off == OFF_TCTRL);
  assign wr_txdata = wr_en && (off == OFF_TXDATA);
  assign wr_txstat = wr_en && (off == OFF_TXSTAT);

  // ---------------------------------------------------------------------------
  // FIFO control: full/empty come from the registered count, so a push seen
  // while full is rejected even if the head pops on the same edge.
  // ---------------------------------------------------------------------------
  logic fifo_full, fifo_empty;
  logic push, pop, ovf_evt;

  assign fifo_full  = (cnt_q == CNT_FULL);
  assign fifo_empty = (cnt_q == '0);
  assign push       = wr_txdata && !fifo_full;
  assign ovf_evt    = wr_txdata &&  fifo_full;
  assign pop        = !fifo_empty && tx_ready;

  assign tx_valid = !fifo_empty;
  assign tx_data  = mem_q[rp_q];
  assign led      = led_q;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push) wp_d = wp_q + PTR_W'(1);
    if (pop)  rp_d = rp_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Overflow is sticky; a fresh overflow outranks a same-edge clear.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_evt)
      ovf_d = 1'b1;
    else if (wr_txstat && wdata[2])
      ovf_d = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Timer
  // ---------------------------------------------------------------------------
  logic tick, timer_inc, wrap_evt;

  assign tick      = en_q && (pre_q == PRE_LAST);
  // A CPU load of TIMER takes priority over the tick on the same edge.
  assign timer_inc = tick && !wr_timer;
  assign wrap_evt  = timer_inc && (timer_q == 16'hFFFF);

  always_comb begin
    pre_d = pre_q;
    if (wr_timer)
      pre_d = '0;
    else if (en_q)
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
  end

  always_comb begin
    timer_d = timer_q;
    if (wr_timer)
      timer_d = wdata;
    else if (timer_inc)
      timer_d = timer_q + 16'd1;
  end

  always_comb begin
    en_d   = wr_tctrl ? wdata[0] : en_q;
    wrap_d = wrap_q;
    // Hardware setting wrap wins over a same-edge write-1-to-clear.
    if (wrap_evt)
      wrap_d = 1'b1;
    else if (wr_tctrl && wdata[1])
      wrap_d = 1'b0;
  end

  always_comb begin
    led_d = wr_led ? wdata[LED_W-1:0] : led_q;
  end

  // ---------------------------------------------------------------------------
  // Read mux (reflects pre-write state when wen and ren coincide)
  // ---------------------------------------------------------------------------
  always_comb begin
    io_rdata = '0;
    if (io_sel && mem_ren) begin
      case (off)
        OFF_LED:    io_rdata[LED_W-1:0] = led_q;
        OFF_SW:     io_rdata[SW_W-1:0]  = sw_sync_q;
        OFF_TIMER:  io_rdata            = timer_q;
        OFF_TCTRL:  io_rdata[1:0]       = {wrap_q, en_q};
        OFF_TXSTAT: begin
          io_rdata[0]   = fifo_full;
          io_rdata[1]   = fifo_empty;
          io_rdata[2]   = ovf_q;
          io_rdata[7:4] = 4'(cnt_q);
        end
        default:    io_rdata = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      timer_q   <= '0;
      pre_q     <= '0;
      en_q      <= 1'b0;
      wrap_q    <= 1'b0;
      ovf_q     <= 1'b0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= sw_in;
      sw_sync_q <= sw_meta_q;
      timer_q   <= timer_d;
      pre_q     <= pre_d;
      en_q      <= en_d;
      wrap_q    <= wrap_d;
      ovf_q     <= ovf_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
    end
  end

  // Storage needs no reset: the count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (rst && push)
      mem_q[wp_q] <= wdata[7:0];
  end

endmodule

// File: tb/tb_stump_io_ctrl.sv
module tb_stump_io_ctrl;

  localparam int DEPTH = 4;
  localparam int PRE   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] address = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic        mem_wen = 1'b0;
  logic        mem_ren = 1'b0;
  logic        io_sel;
  logic [15:0] io_rdata;
  logic [7:0]  sw_in = 8'h00;
  logic [7:0]  led;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  stump_io_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .address  (address),
    .wdata    (wdata),
    .mem_wen  (mem_wen),
    .mem_ren  (mem_ren),
    .io_sel   (io_sel),
    .io_rdata (io_rdata),
    .sw_in    (sw_in),
    .led      (led),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: timer as load + enabled-cycles/PRE, FIFO as a queue,
  // synchroniser as a two-deep history of sampled switch values.
  // ---------------------------------------------------------------------------
  bit         started = 0;
  logic [7:0] m_led = 8'h00;
  int         m_load = 0;
  int         m_elapsed = 0;
  bit         m_en = 0, m_wrap = 0, m_ovf = 0;
  logic [7:0] m_q[$];
  logic [7:0] m_sw[$] = '{8'h00, 8'h00};

  function automatic logic [15:0] m_timer();
    return 16'(m_load + m_elapsed / PRE);
  endfunction

  function automatic logic [15:0] m_read(input logic [15:0] a, input logic ren);
    logic [3:0] cnt;
    if (a[15:4] != 12'hFF0 || !ren) return 16'h0000;
    cnt = 4'(m_q.size());
    case (a[3:0])
      4'd0:    return {8'h00, m_led};
      4'd1:    return {8'h00, m_sw[0]};
      4'd2:    return m_timer();
      4'd3:    return {14'h0, m_wrap, m_en};
      4'd5:    return {8'h00, cnt, 1'b0, m_ovf, (m_q.size() == 0), (m_q.size() == DEPTH)};
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    bit         wr, wrap_set;
    logic [3:0] off;
    bit         was_full;
    started = 1;
    if (!rst) begin
      m_led = 8'h00; m_load = 0; m_elapsed = 0;
      m_en = 0; m_wrap = 0; m_ovf = 0;
      m_q.delete();
      m_sw = '{8'h00, 8'h00};
    end else begin
      wr       = mem_wen && (address[15:4] == 12'hFF0);
      off      = address[3:0];
      wrap_set = 0;
      was_full = (m_q.size() == DEPTH);
      m_sw.push_back(sw_in);
      void'(m_sw.pop_front());
      if (wr && off == 4'd0) m_led = wdata[7:0];
      if (wr && off == 4'd2) begin
        m_load = int'(wdata); m_elapsed = 0;
      end else if (m_en) begin
        if (((m_elapsed + 1) % PRE) == 0 && m_timer() == 16'hFFFF) wrap_set = 1;
        m_elapsed++;
      end
      if (wrap_set) m_wrap = 1;
      if (wr && off == 4'd3) begin
        if (wdata[1] && !wrap_set) m_wrap = 0;
        m_en = wdata[0];
      end
      if (m_q.size() > 0 && tx_ready) void'(m_q.pop_front());
      if (wr && off == 4'd4) begin
        if (was_full) m_ovf = 1;
        else m_q.push_back(wdata[7:0]);
      end
      if (wr && off == 4'd5 && wdata[2]) m_ovf = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("m_io_sel", {15'h0, io_sel}, {15'h0, (address[15:4] == 12'hFF0)});
      check("m_io_rdata", io_rdata, m_read(address, mem_ren));
      check("m_led", {8'h00, led}, {8'h00, m_led});
      check("m_tx_valid", {15'h0, tx_valid}, {15'h0, (m_q.size() > 0)});
      if (m_q.size() > 0) check("m_tx_data", {8'h00, tx_data}, {8'h00, m_q[0]});
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with hand-computed expectations
  // ---------------------------------------------------------------------------
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    address = a; wdata = d; mem_wen = 1'b1;
    @(posedge clk); #1;
    mem_wen = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] a, input logic [15:0] exp);
    address = a; mem_ren = 1'b1;
    @(negedge clk);
    check(nm, io_rdata, exp);
    #1;
    mem_ren = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with a write pending
    rst = 1'b0; mem_wen = 1'b1; address = 16'hFF00; wdata = 16'hFFFF;
    repeat (2) @(posedge clk); #1;
    check("rst_led", {8'h00, led}, 16'h0000);
    check("rst_tx_valid", {15'h0, tx_valid}, 16'h0000);
    rst = 1'b1; mem_wen = 1'b0;
    rd_chk("rst_txstat", 16'hFF05, 16'h0002);

    // LED register and window decode
    wr(16'hFF00, 16'h1234);
    check("led_val", {8'h00, led}, 16'h0034);
    rd_chk("led_read", 16'hFF00, 16'h0034);
    address = 16'hFF20; mem_ren = 1'b1;
    @(negedge clk);
    check("out_win_sel", {15'h0, io_sel}, 16'h0000);
    check("out_win_rdata", io_rdata, 16'h0000);
    #1; mem_ren = 1'b0;
    rd_chk("unmapped_rd", 16'hFF09, 16'h0000);

    // Timer: FFFE -> FFFF after 16 clocks -> 0000 + wrap after 32
    wr(16'hFF02, 16'hFFFE);
    wr(16'hFF03, 16'h0001);
    idle(16);
    rd_chk("timer_ffff", 16'hFF02, 16'hFFFF);
    idle(16);
    rd_chk("timer_wrap0", 16'hFF02, 16'h0000);
    rd_chk("tctrl_wrap", 16'hFF03, 16'h0003);
    wr(16'hFF03, 16'h0003);
    rd_chk("tctrl_w1c", 16'hFF03, 16'h0001);
    wr(16'hFF03, 16'h0000);

    // FIFO fill with consumer stalled, one overflow
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(16'hFF04, 16'h00A1 + 16'(i));
    rd_chk("fifo_full_stat", 16'hFF05, 16'h0045);
    check("fifo_head", {8'h00, tx_data}, 16'h00A1);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", {15'h0, tx_valid}, 16'h0001);
      check("drain_data", {8'h00, tx_data}, 16'h00A1 + 16'(i));
      @(posedge clk); #1;
    end
    check("drain_empty", {15'h0, tx_valid}, 16'h0000);
    tx_ready = 1'b0;
    wr(16'hFF05, 16'h0004);
    rd_chk("ovf_cleared", 16'hFF05, 16'h0002);

    // Push into a full FIFO while the head pops: rejected, count 3
    for (int i = 0; i < 4; i++) wr(16'hFF04, 16'h00B1 + 16'(i));
    tx_ready = 1'b1;
    wr(16'hFF04, 16'h00B5);
    tx_ready = 1'b0;
    rd_chk("full_pushpop", 16'hFF05, 16'h0034);
    tx_ready = 1'b1;
    idle(1);
    tx_ready = 1'b0;
    // Two entries left; simultaneous push and pop keeps count at 2
    tx_ready = 1'b1;
    wr(16'hFF04, 16'h00C1);
    tx_ready = 1'b0;
    rd_chk("half_pushpop", 16'hFF05, 16'h0024);
    check("half_head", {8'h00, tx_data}, 16'h00B4);
    tx_ready = 1'b1;
    idle(1);
    check("order_next", {8'h00, tx_data}, 16'h00C1);
    idle(2);
    tx_ready = 1'b0;
    check("half_drained", {15'h0, tx_valid}, 16'h0000);

    // Switch synchroniser
    sw_in = 8'h5A;
    rd_chk("sw_edge0", 16'hFF01, 16'h0000);
    idle(1);
    rd_chk("sw_edge1", 16'hFF01, 16'h0000);
    idle(2);
    rd_chk("sw_edge3", 16'hFF01, 16'h005A);

    // Reset in the middle of a transfer
    wr(16'hFF04, 16'h00D1);
    wr(16'hFF04, 16'h00D2);
    tx_ready = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_valid", {15'h0, tx_valid}, 16'h0000);
    check("midrst_led", {8'h00, led}, 16'h0000);
    rst = 1'b1; tx_ready = 1'b0;
    rd_chk("midrst_stat", 16'hFF05, 16'h0002);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
